// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell. The result and final borrow appear
// on diff/bout together with a one-cycle done pulse and hold until the next
// completed operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             br_next;

  // Full-subtractor cell; returns {borrow_out, difference}.
  function automatic logic [1:0] fs_cell(input logic ai, input logic bi, input logic bri);
    logic d;
    logic bo;
    d  = ai ^ bi ^ bri;
    bo = (~ai & bi) | (~(ai ^ bi) & bri);
    return {bo, d};
  endfunction

  // Current bit of the operation, taken from the LSBs of the shift registers.
  always_comb begin
    {br_next, d_bit} = fs_cell(a_sh[0], b_sh[0], br);
  end

  // Control FSM plus operand/result datapath; outputs are registered so that
  // partially built results never reach diff/bout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not examined here: a running operation
          // cannot be disturbed by a new request.
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          res  <= {d_bit, res[WIDTH-1:1]};
          if (cnt == LAST_BIT) begin
            diff  <= {d_bit, res[WIDTH-1:1]};
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for timing, reset
// and back-to-back behaviour, and a 4-bit instance swept exhaustively.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one edge on the 8-bit instance, then drop start.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic bv_in);
    a8 = av; b8 = bv; bin8 = bv_in; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Tick until done (bounded); report ticks taken, busy/done overlap, and
  // whether diff/bout kept the held value on every cycle before done.
  task automatic wait_done(input logic [8:0] hold, output int n, output bit overlap,
                           output bit held, output bit timeout);
    n = 0; overlap = 0; held = 1; timeout = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (busy8 && done8) overlap = 1;
      if (done8) begin
        timeout = 0;
        break;
      end
      if ({bout8, diff8} !== hold) held = 0;
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic bv_in, input logic [7:0] ed, input logic eb);
    int n; bit ov, hd, to;
    logic [8:0] prev;
    prev = {bout8, diff8};
    start_op(av, bv, bv_in);
    chk({tag, "_busy_after_start"}, busy8, 1'b1);
    wait_done(prev, n, ov, hd, to);
    chk({tag, "_timeout"}, to, 1'b0);
    chk({tag, "_busy_cycles"}, n, 8);
    chk({tag, "_overlap"}, ov, 1'b0);
    chk({tag, "_held"}, hd, 1'b1);
    chk({tag, "_diff"}, diff8, ed);
    chk({tag, "_bout"}, bout8, eb);
    tick();
    chk({tag, "_done_single"}, {busy8, done8}, 2'b00);
  endtask

  initial begin
    int n; bit ov, hd, to, quiet;
    int errs4;
    logic [4:0] ref5;

    // Reset asserted from time zero, with start requested throughout.
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd1; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    #1;
    chk("reset8_outputs", {busy8, done8, bout8, diff8}, 11'd0);
    chk("reset4_outputs", {busy4, done4, bout4, diff4}, 7'd0);
    tick();
    tick();
    chk("start_ignored_in_reset", {busy8, done8}, 2'b00);
    #2 rst = 1'b0;
    start8 = 1'b0;
    tick();

    // Basic vectors.
    run8("a5_b3", 8'd5, 8'd3, 1'b0, 8'd2, 1'b0);
    run8("a3_b5", 8'd3, 8'd5, 1'b0, 8'd254, 1'b1);
    run8("a0_b0_bin1", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1);
    run8("a255_b255", 8'd255, 8'd255, 1'b0, 8'd0, 1'b0);

    // New start at bit 3 of a run must be ignored: 100-37=63.
    start_op(8'd100, 8'd37, 1'b0);
    tick(); tick(); tick();
    a8 = 8'd7; b8 = 8'd200; bin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("midstart_busy", busy8, 1'b1);
    wait_done({1'b0, 8'd0}, n, ov, hd, to);
    chk("midstart_remaining", n, 4);
    chk("midstart_diff", diff8, 8'd63);
    chk("midstart_bout", bout8, 1'b0);
    tick();

    // Asynchronous reset in the middle of a run.
    start_op(8'd50, 8'd20, 1'b0);
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {busy8, done8, bout8, diff8}, 11'd0);
    #2 rst = 1'b0;
    quiet = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8 || busy8 || diff8 !== 8'd0 || bout8) quiet = 0;
    end
    chk("no_done_after_rst", quiet, 1'b1);

    // Back-to-back: 10-3=7, then start during the DONE cycle with 200-100.
    start_op(8'd10, 8'd3, 1'b0);
    wait_done({1'b0, 8'd0}, n, ov, hd, to);
    chk("b2b_first_diff", {bout8, diff8}, {1'b0, 8'd7});
    chk("b2b_first_done", done8, 1'b1);
    start_op(8'd200, 8'd100, 1'b0);
    chk("b2b_busy_next", {busy8, done8}, 2'b10);
    chk("b2b_hold_first", diff8, 8'd7);
    wait_done({1'b0, 8'd7}, n, ov, hd, to);
    chk("b2b_second_cycles", n, 8);
    chk("b2b_held_until_done", hd, 1'b1);
    chk("b2b_second_result", {bout8, diff8}, {1'b0, 8'd100});
    tick();
    chk("b2b_idle_hold", {busy8, done8, bout8, diff8}, {3'b000, 8'd100});

    // Exhaustive 4-bit sweep against an arithmetic reference.
    errs4 = 0;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci); start4 = 1'b1;
          tick();
          start4 = 1'b0;
          to = 1;
          for (int k = 0; k < 20; k++) begin
            tick();
            if (done4) begin
              to = 0;
              break;
            end
          end
          ref5 = {1'b0, a4} - {1'b0, b4} - {4'd0, bin4};
          if (to || {bout4, diff4} !== ref5) begin
            errs4++;
            if (errs4 <= 5)
              $display("FAIL sweep4 a=%0d b=%0d bin=%0d observed=%0h expected=%0h",
                       ai, bi, ci, {bout4, diff4}, ref5);
          end
        end
      end
    end
    chk("sweep4_mismatches", errs4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
